// File: rtl/geig_pkg.sv
// Shared word layout, FSM encoding and saturation limit for the Geiger
// event integrator.
package geig_pkg;

    localparam int COUNT_W = 16;
    localparam int TS_W    = 24;
    localparam int ID_W    = 8;
    localparam int STACK_W = COUNT_W + TS_W + ID_W;

    localparam int ID_LSB    = 0;
    localparam int TS_LSB    = ID_LSB + ID_W;
    localparam int COUNT_LSB = TS_LSB + TS_W;

    localparam logic [COUNT_W-1:0] ACC_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [STACK_W-1:0] pack_stack(
        input logic [COUNT_W-1:0] count,
        input logic [TS_W-1:0]    ts,
        input logic [ID_W-1:0]    id
    );
        return {count, ts, id};
    endfunction

endpackage

// File: rtl/geig_chan_accum.sv
// One Geiger channel: Gray-bus synchroniser, Gray-to-binary, modular delta
// and a saturating period accumulator with an end-of-period snapshot.
module geig_chan_accum
    import geig_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic               CLK_10HZ,
    input  logic               RESET,
    input  logic [CW-1:0]      gcount_gray,
    input  logic               clr,
    input  logic               snap_ld,
    output logic [COUNT_W-1:0] total,
    output logic [COUNT_W-1:0] snap
);

    logic [CW-1:0]      sync1;
    logic [CW-1:0]      sync2;
    logic [CW-1:0]      bin;
    logic [CW-1:0]      prev;
    logic [CW-1:0]      delta;
    logic [COUNT_W-1:0] acc;
    logic [COUNT_W:0]   sum;

    function automatic logic [CW-1:0] gray2bin(input logic [CW-1:0] g);
        logic [CW-1:0] b;
        for (int i = 0; i < CW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Unsigned subtraction wraps modulo 2^CW, which is exactly the number
    // of events seen across a source-counter rollover.
    always_comb begin
        bin   = gray2bin(sync2);
        delta = bin - prev;
        sum   = {1'b0, acc} + (COUNT_W + 1)'(delta);
        total = sum[COUNT_W] ? ACC_MAX : sum[COUNT_W-1:0];
    end

    // NOTE: non-blocking assignments keep sync1 -> sync2 -> acc a true
    // three-stage pipeline; blocking ones would collapse it into one edge.
    always_ff @(posedge CLK_10HZ or negedge RESET) begin
        if (!RESET) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            acc   <= '0;
            snap  <= '0;
        end else begin
            sync1 <= gcount_gray;
            sync2 <= sync1;
            prev  <= bin;
            acc   <= clr ? '0 : total;
            if (snap_ld) begin
                snap <= total;
            end
        end
    end

endmodule

// File: rtl/geig_multi_integrator.sv
// Multi-channel Geiger integrator: period timer, per-channel accumulators and
// a valid/ack scan that emits one 48-bit stack per enabled channel.
module geig_multi_integrator
    import geig_pkg::*;
#(
    parameter int              NCH       = 4,
    parameter int              CW        = 8,
    parameter int              PERIOD_DS = 600,
    parameter logic [ID_W-1:0] ID_BASE   = 8'h47
) (
    input  logic               CLK_10HZ,
    input  logic               RESET,
    input  logic [TS_W-1:0]    TIMESTAMP,
    input  logic [NCH*CW-1:0]  GCOUNT_GRAY,
    input  logic [NCH-1:0]     CH_EN,
    output logic [STACK_W-1:0] G_DATA_STACK,
    output logic               G_DATA_VALID,
    input  logic               G_DATA_ACK,
    output logic               G_OVERRUN
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = 10;

    logic [PW-1:0]      pcnt;
    logic               period_end;
    logic               snap_ld;
    logic               xfer;
    state_t             state;
    logic [CHW-1:0]     ch;
    logic [TS_W-1:0]    ts_l;
    logic [NCH-1:0]     en_l;
    logic [COUNT_W-1:0] total [NCH];
    logic [COUNT_W-1:0] snap  [NCH];
    logic [CHW-1:0]     first_idx;
    logic               first_ok;
    logic [CHW-1:0]     next_idx;
    logic               next_ok;

    assign period_end = (pcnt == PW'(PERIOD_DS));
    // Snapshots are frozen while a previous emission is still draining.
    assign snap_ld    = period_end && (state == IDLE);
    assign xfer       = G_DATA_VALID && G_DATA_ACK;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        geig_chan_accum #(.CW(CW)) u_chan (
            .CLK_10HZ    (CLK_10HZ),
            .RESET       (RESET),
            .gcount_gray (GCOUNT_GRAY[g*CW +: CW]),
            .clr         (period_end),
            .snap_ld     (snap_ld),
            .total       (total[g]),
            .snap        (snap[g])
        );
    end

    // NOTE: every output gets a default before the loop, so no path through
    // this block can infer a latch.
    always_comb begin
        first_idx = '0;
        first_ok  = 1'b0;
        next_idx  = '0;
        next_ok   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (CH_EN[i]) begin
                first_idx = CHW'(i);
                first_ok  = 1'b1;
            end
            if (en_l[i] && (i > int'(ch))) begin
                next_idx = CHW'(i);
                next_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_10HZ or negedge RESET) begin
        if (!RESET) begin
            pcnt         <= PW'(1);
            state        <= IDLE;
            ch           <= '0;
            ts_l         <= '0;
            en_l         <= '0;
            G_DATA_STACK <= '0;
            G_DATA_VALID <= 1'b0;
            G_OVERRUN    <= 1'b0;
        end else begin
            pcnt <= period_end ? PW'(1) : pcnt + PW'(1);
            case (state)
                IDLE: begin
                    if (period_end) begin
                        ts_l <= TIMESTAMP;
                        en_l <= CH_EN;
                        // First word bypasses the snapshot register being loaded on this edge.
                        if (first_ok) begin
                            state        <= EMIT;
                            ch           <= first_idx;
                            G_DATA_VALID <= 1'b1;
                            G_DATA_STACK <= pack_stack(total[first_idx], TIMESTAMP,
                                                       ID_BASE + ID_W'(first_idx));
                        end
                    end
                end
                EMIT: begin
                    if (period_end) begin
                        G_OVERRUN <= 1'b1;
                    end
                    if (xfer) begin
                        if (next_ok) begin
                            ch           <= next_idx;
                            G_DATA_STACK <= pack_stack(snap[next_idx], ts_l,
                                                       ID_BASE + ID_W'(next_idx));
                        end else begin
                            G_DATA_VALID <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
